// File: rtl/alu_seq_nbits.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and bit-serial shifts.
// Define ALU_SEQ_MUL_EN to enable the iterative shift-add multiplier on op 12.
module alu_seq_nbits #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             less_flag,
  output logic             equal_flag,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero_flag,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd12;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             less;
    logic             equal;
    logic             carry;
    logic             ovf;
    logic             zero;
  } res_t;

  state_e           state_q, state_d;
  res_t             res_q, res_d, alu;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH:0]   sum, diff;
  logic             add_ovf, sub_ovf, zero_op, shift_go;
  logic [WIDTH-1:0] next_val;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mplier_q, mplier_d, prod_q, prod_d;
`endif

  // Single-cycle datapath; shifts only land here when the amount is zero.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    alu     = '0;
    zero_op = 1'b0;
    case (op)
      OP_ADD: begin
        alu.value = sum[WIDTH-1:0];
        alu.carry = sum[WIDTH];
        alu.ovf   = add_ovf;
        zero_op   = 1'b1;
      end
      OP_SUB: begin
        alu.value = diff[WIDTH-1:0];
        alu.carry = diff[WIDTH];
        alu.ovf   = sub_ovf;
        zero_op   = 1'b1;
      end
      OP_NOT: begin alu.value = ~a;    zero_op = 1'b1; end
      OP_AND: begin alu.value = a & b; zero_op = 1'b1; end
      OP_OR:  begin alu.value = a | b; zero_op = 1'b1; end
      OP_XOR: begin alu.value = a ^ b; zero_op = 1'b1; end
      OP_SLT: begin
        alu.less  = sub_ovf ^ diff[WIDTH-1];
        alu.ovf   = sub_ovf;
        alu.value = {{(WIDTH-1){1'b0}}, sub_ovf ^ diff[WIDTH-1]};
      end
      OP_EQ: begin
        alu.equal = (a == b);
        alu.value = {{(WIDTH-1){1'b0}}, a == b};
      end
      OP_SLTU: begin
        alu.less  = ~diff[WIDTH];
        alu.value = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
      end
      OP_SLL, OP_SRL, OP_SRA: begin alu.value = a; zero_op = 1'b1; end
      default: ;
    endcase
    alu.zero = zero_op && (alu.value == '0);
    shift_go = (op == OP_SLL || op == OP_SRL || op == OP_SRA) && (b[SHW-1:0] != '0);
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    next_val = work_q;
`ifdef ALU_SEQ_MUL_EN
    mplier_d = mplier_q;
    prod_d   = prod_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (shift_go) begin
            work_d  = a;
            cnt_d   = {1'b0, b[SHW-1:0]};
            state_d = BUSY;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (op == OP_MUL) begin
            work_d   = a;
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = (SHW+1)'(WIDTH);
            state_d  = BUSY;
          end
`endif
          else begin
            res_d   = alu;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - (SHW+1)'(1);
        // One bit per cycle; SLL and the multiplicand both move left.
        case (op_q)
          OP_SRL:  work_d = work_q >> 1;
          OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
          default: work_d = work_q << 1;
        endcase
        next_val = work_d;
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          if (mplier_q[0]) prod_d = prod_q + work_q;
          mplier_d = mplier_q >> 1;
          next_val = prod_d;
        end
`endif
        if (cnt_q == (SHW+1)'(1)) begin
          res_d       = '0;
          res_d.value = next_val;
          res_d.zero  = (next_val == '0);
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
      mplier_q <= '0;
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
`ifdef ALU_SEQ_MUL_EN
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign result     = res_q.value;
  assign less_flag  = res_q.less;
  assign equal_flag = res_q.equal;
  assign carry_out  = res_q.carry;
  assign overflow   = res_q.ovf;
  assign zero_flag  = res_q.zero;

endmodule

// File: tb/tb_alu_seq_nbits.sv
// Directed bench for alu_seq_nbits: a 4-bit instance for the ALU/shift/handshake
// behaviour and an 8-bit instance for op 12 (MUL or reserved, per ALU_SEQ_MUL_EN).
module tb_alu_seq_nbits;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic         less_flag, equal_flag, carry_out, overflow, zero_flag;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  logic         m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_busy;
  logic         m_less, m_equal, m_carry, m_ovf, m_zero;
  logic [3:0]   m_op;
  logic [7:0]   m_a, m_b, m_result;

  int total = 0;
  int bad   = 0;

  alu_seq_nbits #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .less_flag(less_flag), .equal_flag(equal_flag), .carry_out(carry_out),
    .overflow(overflow), .zero_flag(zero_flag), .busy(busy)
  );

  alu_seq_nbits #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .op(m_op),
    .a(m_a), .b(m_b), .out_valid(m_out_valid), .out_ready(m_out_ready), .result(m_result),
    .less_flag(m_less), .equal_flag(m_equal), .carry_out(m_carry),
    .overflow(m_ovf), .zero_flag(m_zero), .busy(m_busy)
  );

  // Snapshot {result, less, equal, carry, overflow, zero}.
  function automatic logic [W+4:0] obs();
    return {result, less_flag, equal_flag, carry_out, overflow, zero_flag};
  endfunction

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+4:0] exp;
    int           lat;
  } vec_t;

  // Present one op for a single accept edge, then scramble operands.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; op = 4'd13; a = ~x; b = ~y;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_op = '0; m_a = '0; m_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, busy, obs()} !== {1'b1, 1'b0, 1'b0, 9'b0}) begin
      bad++;
      $display("FAIL reset4: got rdy/vld/busy/res/flags=%b want %b",
               {in_ready, out_valid, busy, obs()}, {1'b1, 1'b0, 1'b0, 9'b0});
    end
    total++;
    if ({m_in_ready, m_out_valid, m_busy, m_result, m_less, m_equal, m_carry, m_ovf, m_zero}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 5'b0}) begin
      bad++;
      $display("FAIL reset8: got %b want %b",
               {m_in_ready, m_out_valid, m_busy, m_result, m_less, m_equal, m_carry, m_ovf, m_zero},
               {1'b1, 1'b0, 1'b0, 8'h00, 5'b0});
    end
  endtask

  // exp = {result, less, equal, carry, ovf, zero}
  task automatic test_arith();
    vec_t v [17] = '{
      '{4'd0,  4'b0111, 4'b0001, 9'b1000_00010, 1},
      '{4'd1,  4'b0011, 4'b0011, 9'b0000_00101, 1},
      '{4'd6,  4'b1000, 4'b0001, 9'b0001_10010, 1},
      '{4'd8,  4'b1000, 4'b0001, 9'b0000_00000, 1},
      '{4'd7,  4'b0101, 4'b0101, 9'b0001_01000, 1},
      '{4'd7,  4'b0101, 4'b0100, 9'b0000_00000, 1},
      '{4'd2,  4'b1111, 4'b0000, 9'b0000_00001, 1},
      '{4'd2,  4'b0101, 4'b0000, 9'b1010_00000, 1},
      '{4'd3,  4'b1100, 4'b1010, 9'b1000_00000, 1},
      '{4'd4,  4'b1100, 4'b1010, 9'b1110_00000, 1},
      '{4'd5,  4'b1100, 4'b1010, 9'b0110_00000, 1},
      '{4'd1,  4'b0010, 4'b0011, 9'b1111_00000, 1},
      '{4'd1,  4'b1000, 4'b0001, 9'b0111_00110, 1},
      '{4'd0,  4'b1111, 4'b0001, 9'b0000_00101, 1},
      '{4'd6,  4'b0001, 4'b1000, 9'b0000_00010, 1},
      '{4'd13, 4'b1111, 4'b1111, 9'b0000_00000, 1},
      '{4'd15, 4'b1010, 4'b0101, 9'b0000_00000, 1}
    };
    int lat;
    for (int i = 0; i < 17; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_out(lat);
      total++;
      if (lat !== v[i].lat || obs() !== v[i].exp) begin
        bad++;
        $display("FAIL arith[%0d] op=%0d: got lat=%0d res/flags=%b want lat=%0d %b",
                 i, v[i].op, lat, obs(), v[i].lat, v[i].exp);
      end
      consume();
    end
  endtask

  task automatic test_shift();
    vec_t v [9] = '{
      '{4'd11, 4'b1000, 4'b0011, 9'b1111_00000, 4},
      '{4'd11, 4'b1000, 4'b0000, 9'b1000_00000, 1},
      '{4'd9,  4'b0011, 4'b0010, 9'b1100_00000, 3},
      '{4'd10, 4'b1000, 4'b0011, 9'b0001_00000, 4},
      '{4'd9,  4'b1000, 4'b0001, 9'b0000_00001, 2},
      '{4'd10, 4'b0110, 4'b0001, 9'b0011_00000, 2},
      '{4'd9,  4'b0011, 4'b0101, 9'b0110_00000, 2},
      '{4'd11, 4'b0100, 4'b0010, 9'b0001_00000, 3},
      '{4'd10, 4'b0000, 4'b0000, 9'b0000_00001, 1}
    };
    int lat;
    for (int i = 0; i < 9; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_out(lat);
      total++;
      if (lat !== v[i].lat || obs() !== v[i].exp) begin
        bad++;
        $display("FAIL shift[%0d] op=%0d: got lat=%0d res/flags=%b want lat=%0d %b",
                 i, v[i].op, lat, obs(), v[i].lat, v[i].exp);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(4'd0, 4'b0010, 4'b0011);
    wait_out(lat);
    total++;
    if (lat !== 1 || obs() !== 9'b0101_00000) begin
      bad++;
      $display("FAIL bp_result: got lat=%0d %b want lat=1 %b", lat, obs(), 9'b0101_00000);
    end
    in_valid = 1'b1; op = 4'd1; a = 4'b1111; b = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, obs()} !== {1'b1, 1'b0, 9'b0101_00000}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got vld/rdy/res=%b want %b",
                 i, {out_valid, in_ready, obs()}, {1'b1, 1'b0, 9'b0101_00000});
      end
    end
    in_valid = 1'b0;
    consume();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release: got rdy/vld=%b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    issue(4'd9, 4'b0001, 4'b0011);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, busy, obs()} !== {1'b1, 1'b0, 1'b0, 9'b0}) begin
      bad++;
      $display("FAIL reset_mid: got rdy/vld/busy/res=%b want %b",
               {in_ready, out_valid, busy, obs()}, {1'b1, 1'b0, 1'b0, 9'b0});
    end
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_abort: got out_valid cycles=%0d want 0", seen);
    end
    issue(4'd0, 4'b0001, 4'b0001);
    wait_out(lat);
    total++;
    if (lat !== 1 || obs() !== 9'b0010_00000) begin
      bad++;
      $display("FAIL reset_next_add: got lat=%0d %b want lat=1 %b", lat, obs(), 9'b0010_00000);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    int n_bad = 0;
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 4'b0001; b = 4'b0010; out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) begin
        n_out++;
        if (result !== 4'b0011) n_bad++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (n_out !== 4 || n_bad !== 0) begin
      bad++;
      $display("FAIL back_to_back: got results=%0d wrong=%0d want 4 and 0", n_out, n_bad);
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [7:0] ma [3] = '{8'd13, 8'd16, 8'd255};
    logic [7:0] mb [3] = '{8'd11, 8'd16, 8'd255};
    logic [7:0] mr [3] = '{8'h8F, 8'h00, 8'h01};
    logic [7:0] exp_r;
    logic       exp_z;
    int         exp_lat;
    int         lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_in_valid = 1'b1; m_op = 4'd12; m_a = ma[i]; m_b = mb[i];
      @(negedge clk);
      m_in_valid = 1'b0; m_a = 8'hA5; m_b = 8'h5A;
      lat = 1;
      while (!m_out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
`ifdef ALU_SEQ_MUL_EN
      exp_r = mr[i]; exp_z = (mr[i] == 8'h00); exp_lat = 9;
`else
      exp_r = 8'h00; exp_z = 1'b0; exp_lat = 1;
`endif
      total++;
      if (lat !== exp_lat ||
          {m_result, m_less, m_equal, m_carry, m_ovf, m_zero} !== {exp_r, 4'b0, exp_z}) begin
        bad++;
        $display("FAIL mul8[%0d]: got lat=%0d %b want lat=%0d %b", i, lat,
                 {m_result, m_less, m_equal, m_carry, m_ovf, m_zero}, exp_lat, {exp_r, 4'b0, exp_z});
      end
      m_out_ready = 1'b1;
      @(negedge clk);
      m_out_ready = 1'b0;
    end
    issue(4'd12, 4'b0011, 4'b0101);
    wait_out(lat);
`ifdef ALU_SEQ_MUL_EN
    exp_lat = 5;
    total++;
    if (lat !== exp_lat || obs() !== 9'b1111_00000) begin
      bad++;
      $display("FAIL mul4: got lat=%0d %b want lat=%0d %b", lat, obs(), exp_lat, 9'b1111_00000);
    end
`else
    exp_lat = 1;
    total++;
    if (lat !== exp_lat || obs() !== 9'b0000_00000) begin
      bad++;
      $display("FAIL mul4_reserved: got lat=%0d %b want lat=%0d %b", lat, obs(), exp_lat, 9'b0);
    end
`endif
    consume();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
